// File: rtl/sad_trig_pkg.sv
// Shared types and default field widths for the SAD trigger qualifier.
package sad_trig_pkg;

   localparam int unsigned DefDelayBits   = 16;
   localparam int unsigned DefWidthBits   = 8;
   localparam int unsigned DefHoldoffBits = 16;
   localparam int unsigned DefCountBits   = 16;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StArmed   = 3'd1,
      StDelay   = 3'd2,
      StPulse   = 3'd3,
      StHoldoff = 3'd4,
      StDone    = 3'd5
   } state_e;

   // States in which a new SAD edge cannot be serviced and is counted as missed.
   function automatic logic is_busy(state_e s);
      return s inside {StDelay, StPulse, StHoldoff};
   endfunction

endpackage

// File: rtl/sad_trig_downcounter.sv
// Loadable down-counter that stops at zero and flags it.
module sad_trig_downcounter #(
   parameter int unsigned Width = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [Width-1:0] count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_q <= count_q - Width'(1);
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/sad_trigger_qualifier.sv
// Qualifies the raw SAD match trigger into a delayed, stretched, rate-limited scope trigger
// with saturating issued/missed counters.
module sad_trigger_qualifier
   import sad_trig_pkg::*;
#(
   parameter int unsigned pDELAY_BITS   = DefDelayBits,
   parameter int unsigned pWIDTH_BITS   = DefWidthBits,
   parameter int unsigned pHOLDOFF_BITS = DefHoldoffBits,
   parameter int unsigned pCOUNT_BITS   = DefCountBits
) (
   input  logic                     clk_adc,
   input  logic                     reset_n,
   input  logic                     arm_i,
   input  logic                     sad_trigger_i,
   input  logic [pDELAY_BITS-1:0]   cfg_delay,
   input  logic [pWIDTH_BITS-1:0]   cfg_width,
   input  logic [pHOLDOFF_BITS-1:0] cfg_holdoff,
   input  logic [pCOUNT_BITS-1:0]   cfg_max_triggers,
   output logic                     trigger_o,
   output logic                     armed_o,
   output logic                     done_o,
   output logic [pCOUNT_BITS-1:0]   trig_count_o,
   output logic [pCOUNT_BITS-1:0]   missed_count_o
);

   state_e state_q, state_d;

   logic arm_q, sad_q;
   logic arm_rise, sad_rise;
   logic trigger_q, armed_q, done_q;
   logic ev_load, dly_dec, wid_dec, hld_dec;
   logic dly_zero, wid_zero, hld_zero;
   logic pulse_first, limit_hit;

   logic [pDELAY_BITS-1:0] dly_load_val;
   logic [pWIDTH_BITS-1:0] wid_load_val;
   logic [pCOUNT_BITS-1:0] trig_count_q, trig_count_d;
   logic [pCOUNT_BITS-1:0] missed_count_q, missed_count_d;

   assign arm_rise = arm_i & ~arm_q;
   assign sad_rise = sad_trigger_i & ~sad_q;

   // Delay and width count down to zero inclusive, so load one less than the cycle count.
   assign dly_load_val = cfg_delay - pDELAY_BITS'(1);
   assign wid_load_val = (cfg_width == '0) ? '0 : cfg_width - pWIDTH_BITS'(1);

   // trigger_q lags the state by one cycle, so it is still low in the first PULSE cycle.
   assign pulse_first = (state_q == StPulse) & ~trigger_q;
   assign limit_hit   = (cfg_max_triggers != '0) && (trig_count_d == cfg_max_triggers);

   sad_trig_downcounter #(
      .Width(pDELAY_BITS)
   ) u_delay_cnt (
      .clk_i     (clk_adc),
      .rst_ni    (reset_n),
      .load_i    (ev_load),
      .load_val_i(dly_load_val),
      .dec_i     (dly_dec),
      .zero_o    (dly_zero)
   );

   sad_trig_downcounter #(
      .Width(pWIDTH_BITS)
   ) u_width_cnt (
      .clk_i     (clk_adc),
      .rst_ni    (reset_n),
      .load_i    (ev_load),
      .load_val_i(wid_load_val),
      .dec_i     (wid_dec),
      .zero_o    (wid_zero)
   );

   // Holdoff keeps the raw value so its zero flag tells PULSE whether holdoff is enabled.
   sad_trig_downcounter #(
      .Width(pHOLDOFF_BITS)
   ) u_holdoff_cnt (
      .clk_i     (clk_adc),
      .rst_ni    (reset_n),
      .load_i    (ev_load),
      .load_val_i(cfg_holdoff),
      .dec_i     (hld_dec),
      .zero_o    (hld_zero)
   );

   always_comb begin
      trig_count_d   = trig_count_q;
      missed_count_d = missed_count_q;
      if ((state_q == StIdle) && arm_rise) begin
         trig_count_d   = '0;
         missed_count_d = '0;
      end else begin
         if (pulse_first && (trig_count_q != '1)) begin
            trig_count_d = trig_count_q + pCOUNT_BITS'(1);
         end
         if (sad_rise && is_busy(state_q) && (missed_count_q != '1)) begin
            missed_count_d = missed_count_q + pCOUNT_BITS'(1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ev_load = 1'b0;
      dly_dec = 1'b0;
      wid_dec = 1'b0;
      hld_dec = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (arm_rise) state_d = StArmed;
         end
         StArmed: begin
            if (sad_rise) begin
               ev_load = 1'b1;
               state_d = (cfg_delay != '0) ? StDelay : StPulse;
            end
         end
         StDelay: begin
            if (dly_zero) state_d = StPulse;
            else          dly_dec = 1'b1;
         end
         StPulse: begin
            if (!wid_zero) begin
               wid_dec = 1'b1;
            end else if (limit_hit) begin
               state_d = StDone;
            end else if (!hld_zero) begin
               state_d = StHoldoff;
               hld_dec = 1'b1;
            end else begin
               state_d = StArmed;
            end
         end
         StHoldoff: begin
            if (hld_zero) state_d = StArmed;
            else          hld_dec = 1'b1;
         end
         StDone: begin
            state_d = StDone;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      if ((state_q != StIdle) && !arm_i) state_d = StIdle;
   end

   always_ff @(posedge clk_adc or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StIdle;
         arm_q          <= 1'b0;
         sad_q          <= 1'b0;
         trigger_q      <= 1'b0;
         armed_q        <= 1'b0;
         done_q         <= 1'b0;
         trig_count_q   <= '0;
         missed_count_q <= '0;
      end else begin
         state_q        <= state_d;
         arm_q          <= arm_i;
         sad_q          <= sad_trigger_i;
         // Gating with arm_i drops the outputs on the same edge an abort returns to IDLE.
         trigger_q      <= (state_q == StPulse) & arm_i;
         armed_q        <= (state_q inside {StArmed, StDelay, StPulse, StHoldoff}) & arm_i;
         done_q         <= (state_q == StDone) & arm_i;
         trig_count_q   <= trig_count_d;
         missed_count_q <= missed_count_d;
      end
   end

   assign trigger_o      = trigger_q;
   assign armed_o        = armed_q;
   assign done_o         = done_q;
   assign trig_count_o   = trig_count_q;
   assign missed_count_o = missed_count_q;

endmodule

// File: tb/tb_sad_trigger_qualifier.sv
// Directed bench: stimulus queues expected pulses, a monitor pops and compares each pulse seen.
module tb_sad_trigger_qualifier;

   localparam int CB = 8;

   logic          clk_adc = 1'b0;
   logic          reset_n = 1'b0;
   logic          arm_i = 1'b0;
   logic          sad_trigger_i = 1'b0;
   logic [15:0]   cfg_delay = '0;
   logic [7:0]    cfg_width = 8'd1;
   logic [15:0]   cfg_holdoff = '0;
   logic [CB-1:0] cfg_max_triggers = '0;
   logic          trigger_o, armed_o, done_o;
   logic [CB-1:0] trig_count_o, missed_count_o;

   typedef struct {
      int start;
      int len;
      int tc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   mon_start = 0;
   int   mon_len = 0;
   int   mon_tc = 0;
   logic mon_prev = 1'b0;
   exp_t mon_e;

   always #5 clk_adc = ~clk_adc;
   always @(posedge clk_adc) cyc <= cyc + 1;

   sad_trigger_qualifier #(
      .pDELAY_BITS  (16),
      .pWIDTH_BITS  (8),
      .pHOLDOFF_BITS(16),
      .pCOUNT_BITS  (CB)
   ) dut (
      .clk_adc         (clk_adc),
      .reset_n         (reset_n),
      .arm_i           (arm_i),
      .sad_trigger_i   (sad_trigger_i),
      .cfg_delay       (cfg_delay),
      .cfg_width       (cfg_width),
      .cfg_holdoff     (cfg_holdoff),
      .cfg_max_triggers(cfg_max_triggers),
      .trigger_o       (trigger_o),
      .armed_o         (armed_o),
      .done_o          (done_o),
      .trig_count_o    (trig_count_o),
      .missed_count_o  (missed_count_o)
   );

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk_adc);
   endtask

   // SAD rise sampled at edge n: drive high before edge n, low before edge n+1.
   task automatic rise_at(input int n);
      wait_cyc(n - 1);
      sad_trigger_i = 1'b1;
      @(negedge clk_adc);
      sad_trigger_i = 1'b0;
   endtask

   task automatic expect_pulse(input int k, input int d, input int w, input int tc);
      exp_t e;
      e.start = k + 1 + d;
      e.len   = (w == 0) ? 1 : w;
      e.tc    = tc;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_adc);
   endtask

   // Monitor: measures each trigger pulse (start cycle, length, count at start).
   initial begin
      forever begin
         @(negedge clk_adc);
         if (trigger_o && !mon_prev) begin
            mon_start = cyc;
            mon_len   = 1;
            mon_tc    = int'(trig_count_o);
         end else if (trigger_o) begin
            mon_len++;
         end else if (mon_prev) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_pulse: actual start %0d len %0d required none",
                        mon_start, mon_len);
            end else begin
               mon_e = exp_q.pop_front();
               check("pulse_start", mon_start, mon_e.start);
               check("pulse_len", mon_len, mon_e.len);
               check("pulse_count", mon_tc, mon_e.tc);
            end
         end
         mon_prev = trigger_o;
      end
   end

   initial begin
      #100000;
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog: actual timeout required completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      int k, r1, r2, c;

      tick(3);
      check("rst_trigger", trigger_o, 0);
      check("rst_armed", armed_o, 0);
      check("rst_done", done_o, 0);
      check("rst_trig_count", trig_count_o, 0);
      check("rst_missed", missed_count_o, 0);
      reset_n = 1'b1;

      // Arm and SAD rise together: arming only.
      arm_i = 1'b1;
      sad_trigger_i = 1'b1;
      @(negedge clk_adc);
      sad_trigger_i = 1'b0;
      check("armed_lag", armed_o, 0);
      @(negedge clk_adc);
      check("armed_rise", armed_o, 1);

      // Zero delay, width 1.
      k = cyc + 2;
      expect_pulse(k, 0, 1, 1);
      rise_at(k);
      wait_cyc(k + 4);
      check("t1_trig_count", trig_count_o, 1);
      check("t1_missed", missed_count_o, 0);

      // Delay 5, width 3, holdoff 10; config edits mid-event must not matter.
      cfg_delay = 16'd5;
      cfg_width = 8'd3;
      cfg_holdoff = 16'd10;
      k = cyc + 2;
      expect_pulse(k, 5, 3, 2);
      rise_at(k);
      cfg_width = 8'd9;
      cfg_delay = 16'd1;
      rise_at(k + 4);
      rise_at(k + 17);
      cfg_width = 8'd3;
      cfg_delay = 16'd5;
      expect_pulse(k + 19, 5, 3, 3);
      rise_at(k + 19);
      wait_cyc(k + 40);
      check("t2_missed", missed_count_o, 2);
      check("t2_trig_count", trig_count_o, 3);
      check("t2_armed", armed_o, 1);

      // Trigger limit of 2.
      arm_i = 1'b0;
      tick(2);
      check("t3_disarmed", armed_o, 0);
      cfg_delay = 16'd0;
      cfg_width = 8'd2;
      cfg_holdoff = 16'd0;
      cfg_max_triggers = 8'd2;
      arm_i = 1'b1;
      tick(2);
      check("t3_trig_cleared", trig_count_o, 0);
      check("t3_missed_cleared", missed_count_o, 0);
      r1 = cyc + 2;
      expect_pulse(r1, 0, 2, 1);
      rise_at(r1);
      r2 = r1 + 6;
      expect_pulse(r2, 0, 2, 2);
      rise_at(r2);
      wait_cyc(r2 + 2);
      check("t3_done_early", done_o, 0);
      wait_cyc(r2 + 3);
      check("t3_done", done_o, 1);
      check("t3_armed_in_done", armed_o, 0);
      rise_at(r2 + 6);
      rise_at(r2 + 12);
      wait_cyc(r2 + 15);
      check("t3_trig_count", trig_count_o, 2);
      check("t3_missed_in_done", missed_count_o, 0);
      check("t3_done_held", done_o, 1);
      arm_i = 1'b0;
      tick(2);
      check("t3_done_cleared", done_o, 0);

      // Abort mid-pulse truncates; counters held until re-arm.
      cfg_width = 8'd20;
      cfg_max_triggers = 8'd0;
      arm_i = 1'b1;
      tick(2);
      k = cyc + 2;
      exp_q.push_back('{start: k + 1, len: 5, tc: 1});
      rise_at(k);
      rise_at(k + 3);
      wait_cyc(k + 5);
      arm_i = 1'b0;
      wait_cyc(k + 8);
      check("t4_armed", armed_o, 0);
      check("t4_trig_held", trig_count_o, 1);
      check("t4_missed_held", missed_count_o, 1);
      arm_i = 1'b1;
      tick(2);
      check("t4_rearm_trig", trig_count_o, 0);
      check("t4_rearm_missed", missed_count_o, 0);

      // Width 0 gives a 1-cycle pulse.
      cfg_delay = 16'd2;
      cfg_width = 8'd0;
      k = cyc + 2;
      expect_pulse(k, 2, 0, 1);
      rise_at(k);
      wait_cyc(k + 6);
      check("t5_trig_count", trig_count_o, 1);

      // Asynchronous reset mid-delay, arm held high through release.
      cfg_delay = 16'd50;
      k = cyc + 2;
      rise_at(k);
      wait_cyc(k + 5);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_trigger", trigger_o, 0);
      check("t6_armed", armed_o, 0);
      check("t6_done", done_o, 0);
      check("t6_trig_count", trig_count_o, 0);
      check("t6_missed", missed_count_o, 0);
      @(negedge clk_adc);
      reset_n = 1'b1;
      c = cyc;
      wait_cyc(c + 1);
      check("t6_armed_lag", armed_o, 0);
      wait_cyc(c + 2);
      check("t6_rearmed", armed_o, 1);

      // Missed counter saturation during a long delay.
      cfg_delay = 16'd1000;
      k = cyc + 2;
      rise_at(k);
      for (int i = 0; i < 300; i++) rise_at(k + 2 + 2 * i);
      tick(1);
      check("t7_missed_sat", missed_count_o, (1 << CB) - 1);
      check("t7_armed", armed_o, 1);
      arm_i = 1'b0;
      tick(10);
      check("pending_pulses", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
